rdm_harq_combine: RTL

- Downstream consumer of the rate-dematching read stage.
- Requests one user's rate-dematched LLR stream (96-bit words, 16 lanes x 6-bit signed) and reads the matching words of that user's HARQ soft buffer.
- Saturating-adds each RDM word to the stored word, or overwrites on a new transmission, and writes the result back.
- Signals completion to the combine controller.

---
 rtl/rdm_harq_combine_if.sv | 40 ++++
 rtl/rdm_harq_combine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rdm_harq_combine_if.sv
// RDM stream and HARQ soft-buffer bus seen by the HARQ combine block.
// master = combine block, slave = RDM stage plus HARQ buffer.
interface rdm_harq_combine_if;
    logic        rdm_data_request;   // one-cycle stream request
    logic        rdm_data_valid;
    logic        rdm_data_comp;
    logic [95:0] rdm_data_content;   // 16 lanes x 6-bit signed LLR
    logic        harq_rd_enable;     // data returns one cycle later
    logic [15:0] harq_rd_address;
    logic [95:0] harq_rd_data;
    logic        harq_wr_enable;
    logic [15:0] harq_wr_address;
    logic [95:0] harq_wr_data;

    modport master (
        output rdm_data_request,
        input  rdm_data_valid,
        input  rdm_data_comp,
        input  rdm_data_content,
        output harq_rd_enable,
        output harq_rd_address,
        input  harq_rd_data,
        output harq_wr_enable,
        output harq_wr_address,
        output harq_wr_data
    );

    modport slave (
        input  rdm_data_request,
        output rdm_data_valid,
        output rdm_data_comp,
        output rdm_data_content,
        input  harq_rd_enable,
        input  harq_rd_address,
        output harq_rd_data,
        input  harq_wr_enable,
        input  harq_wr_address,
        input  harq_wr_data
    );
endinterface

// File: rtl/rdm_harq_combine.sv
// HARQ soft combining: reads one user's RDM stream, saturating-adds each word
// to the stored HARQ word (or overwrites on a new transmission) and writes it back.
module rdm_harq_combine #(
    parameter int unsigned USER_WORDS = 1600,
    parameter int          LLR_MAX    = 31
) (
    input  logic                       i_core_clk,
    input  logic                       i_rx_rst,
    input  logic                       i_Combine_process_request,
    input  logic [3:0]                 i_Combine_user_index,
    input  logic [15:0]                i_Current_Combine_Ncb_Size,
    input  logic                       i_New_Transmission,
    output logic                       o_Combine_Busy,
    output logic                       o_Combine_Done,
    output logic                       o_Combine_Error,
    rdm_harq_combine_if.master         harq_bus
);

    typedef enum logic [2:0] {StIdle, StRequest, StReceive, StFlush, StDone} state_e;

    localparam logic signed [6:0] SatPos = 7'(LLR_MAX);
    localparam logic signed [6:0] SatNeg = -SatPos;

    state_e      state_q;
    logic [15:0] base_q;
    logic [15:0] ncb_q;
    logic        new_tx_q;
    logic [12:0] word_cnt_q;
    logic        flush_cnt_q;
    logic        req_q;
    logic        done_q;
    logic        busy_q;
    logic        err_q;

    // Stage 1: accepted RDM word waiting for its HARQ read data
    logic        s1_vld_q;
    logic [15:0] s1_addr_q;
    logic [95:0] s1_rdm_q;
    logic [15:0] s1_mask_q;

    // Stage 2: registered write port
    logic        wr_en_q;
    logic [15:0] wr_addr_q;
    logic [95:0] wr_data_q;

    logic [12:0] exp_words;
    logic        in_range;
    logic        rd_fire;
    logic        last_word;
    logic [15:0] rd_addr;
    logic [15:0] lane_mask;
    logic [12:0] word_cnt_next;
    logic [95:0] comb_data;

    // Read side decode: accept, bound check, address and last-word lane mask
    always_comb begin
        exp_words     = {1'b0, ncb_q[15:4]} + 13'(|ncb_q[3:0]);
        in_range      = word_cnt_q < exp_words;
        rd_fire       = (state_q == StReceive) && harq_bus.rdm_data_valid && in_range && !i_rx_rst;
        last_word     = word_cnt_q == (exp_words - 13'd1);
        rd_addr       = rd_fire ? (base_q + {3'b000, word_cnt_q}) : 16'd0;
        word_cnt_next = word_cnt_q + 13'(rd_fire);
        lane_mask     = '0;
        for (int k = 0; k < 16; k++) begin
            lane_mask[k] = !last_word || (ncb_q[3:0] == 4'd0) || (4'(k) < ncb_q[3:0]);
        end
    end

    // Per-lane saturating add of the stage-1 RDM word and the returned HARQ word
    always_comb begin
        logic signed [5:0] r;
        logic signed [5:0] h;
        logic signed [6:0] sum;
        comb_data = '0;
        r         = '0;
        h         = '0;
        sum       = '0;
        for (int k = 0; k < 16; k++) begin
            r   = s1_rdm_q[6*k +: 6];
            h   = new_tx_q ? 6'sd0 : harq_bus.harq_rd_data[6*k +: 6];
            sum = {r[5], r} + {h[5], h};
            if (!s1_mask_q[k]) begin
                comb_data[6*k +: 6] = 6'd0;
            end else if (sum > SatPos) begin
                comb_data[6*k +: 6] = SatPos[5:0];
            end else if (sum < SatNeg) begin
                comb_data[6*k +: 6] = SatNeg[5:0];
            end else begin
                comb_data[6*k +: 6] = sum[5:0];
            end
        end
    end

    // Control FSM with registered request/busy/done/error outputs
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            ncb_q       <= '0;
            new_tx_q    <= 1'b0;
            word_cnt_q  <= '0;
            flush_cnt_q <= 1'b0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_Combine_process_request) begin
                        base_q     <= 16'(i_Combine_user_index * USER_WORDS);
                        ncb_q      <= i_Current_Combine_Ncb_Size;
                        new_tx_q   <= i_New_Transmission;
                        word_cnt_q <= '0;
                        err_q      <= 1'b0;
                        req_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StRequest;
                    end
                end
                StRequest: state_q <= StReceive;
                StReceive: begin
                    word_cnt_q <= word_cnt_next;
                    // Words past the expected count are dropped and flagged
                    if (harq_bus.rdm_data_valid && !in_range) err_q <= 1'b1;
                    if (harq_bus.rdm_data_comp) begin
                        if (word_cnt_next != exp_words) err_q <= 1'b1;
                        flush_cnt_q <= 1'b0;
                        state_q     <= StFlush;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        flush_cnt_q <= 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Two-stage read-combine-write pipeline
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_rdm_q  <= '0;
            s1_mask_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            s1_vld_q <= rd_fire;
            wr_en_q  <= s1_vld_q;
            if (rd_fire) begin
                s1_addr_q <= rd_addr;
                s1_rdm_q  <= harq_bus.rdm_data_content;
                s1_mask_q <= lane_mask;
            end
            if (s1_vld_q) begin
                wr_addr_q <= s1_addr_q;
                wr_data_q <= comb_data;
            end
        end
    end

    assign harq_bus.rdm_data_request = req_q;
    assign harq_bus.harq_rd_enable   = rd_fire;
    assign harq_bus.harq_rd_address  = rd_addr;
    assign harq_bus.harq_wr_enable   = wr_en_q;
    assign harq_bus.harq_wr_address  = wr_addr_q;
    assign harq_bus.harq_wr_data     = wr_data_q;
    assign o_Combine_Busy            = busy_q;
    assign o_Combine_Done            = done_q;
    assign o_Combine_Error           = err_q;

endmodule
